// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial bit source with a one-word holding buffer.
// A word accepted on din is sent one bit per clock on b. The first bit appears
// one cycle after the accept. A second word can be queued in the hold register
// while the current word is shifting, so back-to-back words stream with no gap.
// A word offered on the last-bit edge while the hold register is empty goes
// straight into the shifter. Between words, b idles at IDLE_BIT.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             b,
    output logic             b_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             b_q, b_d;
    logic             b_valid_q, b_valid_d;
    logic             word_done_q, word_done_d;

    logic             accept_s;
    logic             load_s;
    logic [WIDTH-1:0] load_word_s;

    // Bit that goes on the wire first for a freshly loaded word.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            first_bit = w[WIDTH-1];
        end else begin
            first_bit = w[0];
        end
    endfunction

    // Moves the next bit to send into the first_bit position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            advance = {w[WIDTH-2:0], 1'b0};
        end else begin
            advance = {1'b0, w[WIDTH-1:1]};
        end
    endfunction

    // Ready depends only on the hold flag, and is held low during reset.
    assign din_ready = ~hold_full_q & rst;
    assign accept_s  = din_valid & din_ready;

    assign b         = b_q;
    assign b_valid   = b_valid_q;
    assign word_done = word_done_q;
    assign busy      = b_valid_q | hold_full_q;

    // Next-state logic: choose a load source, advance the shifter, or go idle.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        b_d         = b_q;
        b_valid_d   = b_valid_q;
        word_done_d = word_done_q;
        load_s      = 1'b0;
        load_word_s = din;

        case (state_q)
            S_IDLE: begin
                b_d         = IDLE_BIT;
                b_valid_d   = 1'b0;
                word_done_d = 1'b0;
                if (accept_s) begin
                    load_s      = 1'b1;
                    load_word_s = din;
                end else begin
                    cnt_d = '0;
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    if (hold_full_q) begin
                        // Drain the queued word with no idle cycle.
                        load_s      = 1'b1;
                        load_word_s = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept_s) begin
                        // Bypass: the word offered on the last bit goes straight in.
                        load_s      = 1'b1;
                        load_word_s = din;
                    end else begin
                        state_d     = S_IDLE;
                        b_d         = IDLE_BIT;
                        b_valid_d   = 1'b0;
                        word_done_d = 1'b0;
                        cnt_d       = '0;
                    end
                end else begin
                    b_d         = first_bit(shift_q);
                    shift_d     = advance(shift_q);
                    cnt_d       = cnt_q + CW'(1);
                    word_done_d = ((cnt_q + CW'(1)) == LAST_CNT);
                    if (accept_s) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end else begin
                        hold_d = hold_q;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                hold_full_d = 1'b0;
                cnt_d       = '0;
                b_d         = IDLE_BIT;
                b_valid_d   = 1'b0;
                word_done_d = 1'b0;
            end
        endcase

        if (load_s) begin
            state_d     = S_SHIFT;
            b_d         = first_bit(load_word_s);
            shift_d     = advance(load_word_s);
            cnt_d       = '0;
            b_valid_d   = 1'b1;
            word_done_d = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            b_q         <= IDLE_BIT;
            b_valid_q   <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            b_q         <= b_d;
            b_valid_q   <= b_valid_d;
            word_done_q <= word_done_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed testbench for bit_serializer: MSB-first instance for most cases,
// plus an LSB-first instance for bit ordering.
module tb_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din_s;
    logic       din_valid_s;
    logic       din_ready_s, b_s, b_valid_s, word_done_s, busy_s;
    logic [7:0] din_l_s;
    logic       din_valid_l_s;
    logic       din_ready_l_s, b_l_s, b_valid_l_s, word_done_l_s, busy_l_s;

    int n_checks = 0;
    int n_fail   = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din_s), .din_valid(din_valid_s),
        .din_ready(din_ready_s), .b(b_s), .b_valid(b_valid_s),
        .word_done(word_done_s), .busy(busy_s)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .din(din_l_s), .din_valid(din_valid_l_s),
        .din_ready(din_ready_l_s), .b(b_l_s), .b_valid(b_valid_l_s),
        .word_done(word_done_l_s), .busy(busy_l_s)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " b"}, {31'd0, b_s}, 32'd1);
        check_eq({tag, " b_valid"}, {31'd0, b_valid_s}, 32'd0);
        check_eq({tag, " busy"}, {31'd0, busy_s}, 32'd0);
        check_eq({tag, " din_ready"}, {31'd0, din_ready_s}, 32'd1);
    endtask

    initial begin
        logic [7:0]  w8;
        logic [15:0] w16;
        logic [23:0] w24;

        rst = 1'b0;
        din_s = 8'h00;
        din_valid_s = 1'b0;
        din_l_s = 8'h00;
        din_valid_l_s = 1'b0;
        tick();
        tick();
        check_eq("rst b", {31'd0, b_s}, 32'd1);
        check_eq("rst b_valid", {31'd0, b_valid_s}, 32'd0);
        check_eq("rst word_done", {31'd0, word_done_s}, 32'd0);
        check_eq("rst busy", {31'd0, busy_s}, 32'd0);
        check_eq("rst din_ready", {31'd0, din_ready_s}, 32'd0);
        rst = 1'b1;
        tick();
        check_idle("post_rst");

        // Test 1: single word 8'h24, MSB first.
        w8 = 8'h24;
        din_s = w8;
        din_valid_s = 1'b1;
        tick();
        din_valid_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t1 b[%0d]", i), {31'd0, b_s}, {31'd0, w8[7-i]});
            check_eq($sformatf("t1 b_valid[%0d]", i), {31'd0, b_valid_s}, 32'd1);
            check_eq($sformatf("t1 word_done[%0d]", i), {31'd0, word_done_s}, (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        check_idle("t1 end");

        // Test 2: 8'hA5 then 8'h3C offered during bit 2, queued in the hold.
        w16 = 16'hA53C;
        din_s = 8'hA5;
        din_valid_s = 1'b1;
        tick();
        din_valid_s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t2 b[%0d]", i), {31'd0, b_s}, {31'd0, w16[15-i]});
            check_eq($sformatf("t2 b_valid[%0d]", i), {31'd0, b_valid_s}, 32'd1);
            check_eq($sformatf("t2 word_done[%0d]", i), {31'd0, word_done_s},
                     (i == 7 || i == 15) ? 32'd1 : 32'd0);
            check_eq($sformatf("t2 din_ready[%0d]", i), {31'd0, din_ready_s},
                     (i >= 3 && i <= 7) ? 32'd0 : 32'd1);
            check_eq($sformatf("t2 busy[%0d]", i), {31'd0, busy_s}, 32'd1);
            if (i == 2) begin
                din_s = 8'h3C;
                din_valid_s = 1'b1;
            end else begin
                din_valid_s = 1'b0;
            end
            tick();
        end
        check_idle("t2 end");

        // Test 3: bypass of 8'hFF on the last-bit edge of 8'h00.
        w16 = 16'h00FF;
        din_s = 8'h00;
        din_valid_s = 1'b1;
        tick();
        din_valid_s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t3 b[%0d]", i), {31'd0, b_s}, {31'd0, w16[15-i]});
            check_eq($sformatf("t3 b_valid[%0d]", i), {31'd0, b_valid_s}, 32'd1);
            check_eq($sformatf("t3 word_done[%0d]", i), {31'd0, word_done_s},
                     (i == 7 || i == 15) ? 32'd1 : 32'd0);
            check_eq($sformatf("t3 din_ready[%0d]", i), {31'd0, din_ready_s}, 32'd1);
            if (i == 7) begin
                din_s = 8'hFF;
                din_valid_s = 1'b1;
            end else begin
                din_valid_s = 1'b0;
            end
            tick();
        end
        check_idle("t3 end");

        // Test 6: valid held while the hold is full; exactly one copy of each word.
        w24 = 24'h814299;
        din_s = 8'h81;
        din_valid_s = 1'b1;
        tick();
        din_valid_s = 1'b0;
        for (int i = 0; i < 24; i++) begin
            check_eq($sformatf("t6 b[%0d]", i), {31'd0, b_s}, {31'd0, w24[23-i]});
            check_eq($sformatf("t6 b_valid[%0d]", i), {31'd0, b_valid_s}, 32'd1);
            check_eq($sformatf("t6 word_done[%0d]", i), {31'd0, word_done_s},
                     (i == 7 || i == 15 || i == 23) ? 32'd1 : 32'd0);
            check_eq($sformatf("t6 din_ready[%0d]", i), {31'd0, din_ready_s},
                     ((i >= 2 && i <= 7) || (i >= 9 && i <= 15)) ? 32'd0 : 32'd1);
            if (i == 1) begin
                din_s = 8'h42;
                din_valid_s = 1'b1;
            end else if (i >= 2 && i <= 8) begin
                din_s = 8'h99;
                din_valid_s = 1'b1;
            end else begin
                din_valid_s = 1'b0;
            end
            tick();
        end
        check_idle("t6 end");
        tick();
        check_idle("t6 idle2");

        // Test 4: asynchronous reset mid-word at bit 3 of 8'h0F.
        din_s = 8'h0F;
        din_valid_s = 1'b1;
        tick();
        din_valid_s = 1'b0;
        tick();
        tick();
        tick();
        check_eq("t4 b_valid before rst", {31'd0, b_valid_s}, 32'd1);
        check_eq("t4 bit3 before rst", {31'd0, b_s}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t4 async b", {31'd0, b_s}, 32'd1);
        check_eq("t4 async b_valid", {31'd0, b_valid_s}, 32'd0);
        check_eq("t4 async busy", {31'd0, busy_s}, 32'd0);
        check_eq("t4 async din_ready", {31'd0, din_ready_s}, 32'd0);
        check_eq("t4 async word_done", {31'd0, word_done_s}, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check_idle("t4 release");
        for (int i = 0; i < 10; i++) begin
            tick();
            check_idle($sformatf("t4 after[%0d]", i));
        end

        // Test 5: LSB-first ordering with 8'h01, then 8'h2C for a richer pattern.
        din_l_s = 8'h01;
        din_valid_l_s = 1'b1;
        tick();
        din_valid_l_s = 1'b0;
        w8 = 8'h01;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t5 b[%0d]", i), {31'd0, b_l_s}, {31'd0, w8[i]});
            check_eq($sformatf("t5 b_valid[%0d]", i), {31'd0, b_valid_l_s}, 32'd1);
            check_eq($sformatf("t5 word_done[%0d]", i), {31'd0, word_done_l_s}, (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        check_eq("t5 idle b", {31'd0, b_l_s}, 32'd1);
        check_eq("t5 idle b_valid", {31'd0, b_valid_l_s}, 32'd0);
        din_l_s = 8'h2C;
        din_valid_l_s = 1'b1;
        tick();
        din_valid_l_s = 1'b0;
        w8 = 8'h2C;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t5b b[%0d]", i), {31'd0, b_l_s}, {31'd0, w8[i]});
            tick();
        end
        check_eq("t5b idle b_valid", {31'd0, b_valid_l_s}, 32'd0);
        check_eq("t5b idle busy", {31'd0, busy_l_s}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
